// File: rtl/pc_fetch_unit.sv
// Program-counter stage: registered fetch address with stall, taken-branch
// redirect plus a one-cycle squash bubble, and a boot cycle after reset.
module pc_fetch_unit #(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      STEP         = 1
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             STALL,
    input  logic             BR_TAKEN,
    input  logic [WIDTH-1:0] BR_TARGET,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC_PLUS,
    output logic             VALID,
    output logic [1:0]       STATE
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pc_q;
    logic             valid_q;

    // Link address; wraps modulo 2^WIDTH with the carry discarded.
    assign PC_PLUS = pc_q + STEP_W;

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state   <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state   <= ST_RUN;
                    valid_q <= 1'b1;
                end
                ST_RUN: begin
                    // Redirect outranks stall; a stall freezes everything.
                    if (BR_TAKEN) begin
                        state   <= ST_FLUSH;
                        pc_q    <= BR_TARGET;
                        valid_q <= 1'b0;
                    end else if (!STALL) begin
                        pc_q    <= PC_PLUS;
                        valid_q <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // Redirects from the squashed slot are dropped here.
                    state   <= ST_RUN;
                    valid_q <= 1'b1;
                end
                default: begin
                    state   <= ST_BOOT;
                    pc_q    <= RESET_VECTOR;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign PC    = pc_q;
    assign VALID = valid_q;
    assign STATE = state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit against a cycle-level reference model.
`timescale 1ns/1ps
module tb_pc_fetch_unit;

    logic       CLK = 1'b0;
    logic       R = 1'b1;
    logic       STALL = 1'b0;
    logic       BR_TAKEN = 1'b0;
    logic [7:0] BR_TARGET = 8'h00;
    logic [7:0] PC;
    logic [7:0] PC_PLUS;
    logic       VALID;
    logic [1:0] STATE;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: fetch address, valid flag, and phase (0 boot, 1 run, 2 bubble).
    logic [7:0] m_pc;
    logic       m_valid;
    int         m_phase;

    pc_fetch_unit #(.WIDTH(8), .RESET_VECTOR(8'h10), .STEP(1)) dut (
        .CLK(CLK), .R(R), .STALL(STALL), .BR_TAKEN(BR_TAKEN),
        .BR_TARGET(BR_TARGET), .PC(PC), .PC_PLUS(PC_PLUS),
        .VALID(VALID), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    function automatic logic [1:0] phase_code(input int ph);
        return (ph == 0) ? 2'b00 : (ph == 1) ? 2'b01 : 2'b10;
    endfunction

    task automatic model_reset();
        m_pc = 8'h10; m_valid = 1'b0; m_phase = 0;
    endtask

    task automatic model_edge(input logic s, input logic b, input logic [7:0] t);
        if (m_phase == 0) begin
            m_phase = 1; m_valid = 1'b1;
        end else if (m_phase == 2) begin
            m_phase = 1; m_valid = 1'b1;
        end else if (b) begin
            m_pc = t; m_valid = 1'b0; m_phase = 2;
        end else if (!s) begin
            m_pc = 8'((int'(m_pc) + 1) % 256); m_valid = 1'b1;
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle 1ns after.
    task automatic tick(input logic s, input logic b, input logic [7:0] t);
        STALL = s; BR_TAKEN = b; BR_TARGET = t;
        @(posedge CLK);
        model_edge(s, b, t);
        #1;
    endtask

    task automatic run_to(input logic [7:0] target, input string tag);
        int budget = 300;
        while (m_pc != target && budget > 0) begin
            tick(1'b0, 1'b0, 8'h00);
            budget--;
        end
        n_cmp++;
        if (PC !== target) begin
            n_fail++;
            $display("FAIL %s_reach: PC=%h required %h", tag, PC, target);
        end
    endtask

    task automatic test_reset();
        R = 1'b1;
        model_reset();
        #12;
        n_cmp++; if (PC !== 8'h10) begin n_fail++; $display("FAIL reset_pc: got %h want 10", PC); end
        n_cmp++; if (VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", VALID); end
        n_cmp++; if (STATE !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", STATE); end
        n_cmp++; if (PC_PLUS !== 8'h11) begin n_fail++; $display("FAIL reset_pcplus: got %h want 11", PC_PLUS); end
        @(posedge CLK); #1;
        R = 1'b0;
    endtask

    task automatic test_boot_run();
        tick(1'b0, 1'b0, 8'h00);
        n_cmp++; if (PC !== 8'h10 || VALID !== 1'b1 || STATE !== 2'b01) begin
            n_fail++; $display("FAIL boot_first: PC=%h V=%b S=%b want 10/1/01", PC, VALID, STATE);
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            n_cmp++; if (PC !== m_pc || VALID !== m_valid) begin
                n_fail++; $display("FAIL run_seq: PC=%h V=%b want %h/%b", PC, VALID, m_pc, m_valid);
            end
            n_cmp++; if (PC_PLUS !== 8'(m_pc + 8'h01)) begin
                n_fail++; $display("FAIL run_pcplus: got %h want %h", PC_PLUS, 8'(m_pc + 8'h01));
            end
        end
    endtask

    task automatic test_stall();
        run_to(8'h14, "stall");
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 8'h00);
            n_cmp++; if (PC !== 8'h14 || VALID !== 1'b1 || STATE !== 2'b01) begin
                n_fail++; $display("FAIL stall_hold: PC=%h V=%b S=%b want 14/1/01", PC, VALID, STATE);
            end
        end
        tick(1'b0, 1'b0, 8'h00);
        n_cmp++; if (PC !== 8'h15) begin n_fail++; $display("FAIL stall_release: got %h want 15", PC); end
    endtask

    task automatic test_branch();
        run_to(8'h20, "branch");
        tick(1'b1, 1'b1, 8'h80);
        n_cmp++; if (PC !== 8'h80 || VALID !== 1'b0 || STATE !== 2'b10) begin
            n_fail++; $display("FAIL branch_take: PC=%h V=%b S=%b want 80/0/10", PC, VALID, STATE);
        end
        tick(1'b0, 1'b1, 8'h40);
        n_cmp++; if (PC !== 8'h80 || VALID !== 1'b1 || STATE !== 2'b01) begin
            n_fail++; $display("FAIL flush_ignore: PC=%h V=%b S=%b want 80/1/01", PC, VALID, STATE);
        end
        tick(1'b0, 1'b0, 8'h00);
        n_cmp++; if (PC !== 8'h81) begin n_fail++; $display("FAIL branch_resume: got %h want 81", PC); end
        // BOOT must ignore a redirect and a stall.
        test_reset();
        tick(1'b1, 1'b1, 8'h40);
        n_cmp++; if (PC !== 8'h10 || VALID !== 1'b1 || STATE !== 2'b01) begin
            n_fail++; $display("FAIL boot_ignore: PC=%h V=%b S=%b want 10/1/01", PC, VALID, STATE);
        end
    endtask

    task automatic test_wrap();
        tick(1'b0, 1'b1, 8'hFE);
        tick(1'b0, 1'b0, 8'h00);
        n_cmp++; if (PC !== 8'hFE || VALID !== 1'b1) begin
            n_fail++; $display("FAIL wrap_fe: PC=%h V=%b want fe/1", PC, VALID);
        end
        tick(1'b0, 1'b0, 8'h00);
        n_cmp++; if (PC !== 8'hFF || PC_PLUS !== 8'h00) begin
            n_fail++; $display("FAIL wrap_ff: PC=%h PC_PLUS=%h want ff/00", PC, PC_PLUS);
        end
        tick(1'b0, 1'b0, 8'h00);
        n_cmp++; if (PC !== 8'h00) begin n_fail++; $display("FAIL wrap_00: got %h want 00", PC); end
        tick(1'b0, 1'b0, 8'h00);
        n_cmp++; if (PC !== 8'h01) begin n_fail++; $display("FAIL wrap_01: got %h want 01", PC); end
    endtask

    task automatic test_async_reset();
        run_to(8'h33, "areset");
        tick(1'b1, 1'b1, 8'h99);
        tick(1'b1, 1'b0, 8'h00);
        run_to(8'h33, "areset2");
        tick(1'b1, 1'b0, 8'h00);
        #3;
        R = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (PC !== 8'h10 || VALID !== 1'b0 || STATE !== 2'b00) begin
            n_fail++; $display("FAIL async_reset: PC=%h V=%b S=%b want 10/0/00", PC, VALID, STATE);
        end
        BR_TAKEN = 1'b1; BR_TARGET = 8'h77;
        @(posedge CLK); #1;
        n_cmp++; if (PC !== 8'h10 || STATE !== 2'b00) begin
            n_fail++; $display("FAIL reset_hold: PC=%h S=%b want 10/00", PC, STATE);
        end
        R = 1'b0;
        tick(1'b0, 1'b0, 8'h00);
        n_cmp++; if (PC !== 8'h10 || VALID !== 1'b1) begin
            n_fail++; $display("FAIL rerun_boot: PC=%h V=%b want 10/1", PC, VALID);
        end
        for (int i = 1; i <= 2; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            n_cmp++; if (PC !== 8'(8'h10 + 8'(i))) begin
                n_fail++; $display("FAIL rerun_seq: got %h want %h", PC, 8'(8'h10 + 8'(i)));
            end
        end
    endtask

    task automatic test_random();
        logic s, b;
        logic [7:0] t;
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(3) == 0);
            b = ($urandom_range(5) == 0);
            t = 8'($urandom_range(255));
            tick(s, b, t);
            n_cmp++; if (PC !== m_pc || VALID !== m_valid || STATE !== phase_code(m_phase)) begin
                n_fail++;
                $display("FAIL rand_%0d: PC=%h V=%b S=%b want %h/%b/%b",
                         i, PC, VALID, STATE, m_pc, m_valid, phase_code(m_phase));
            end
            n_cmp++; if (PC_PLUS !== 8'(m_pc + 8'h01)) begin
                n_fail++; $display("FAIL rand_pcplus_%0d: got %h want %h", i, PC_PLUS, 8'(m_pc + 8'h01));
            end
        end
    endtask

    initial begin
        test_reset();
        test_boot_run();
        test_stall();
        test_branch();
        test_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
